// File: rtl/data_ram.sv
// Data memory for the RV32I load/store path: one write port with byte strobes, one read
// port with 1- or 2-cycle latency, configurable read-during-write result and a read-valid
// pulse. After reset the array is zeroed one word per cycle while busy is high.
module data_ram #(
  parameter int unsigned MEM_WIDTH    = 32,
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RDW_MODE     = 0,
  localparam int unsigned ADDR_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
  localparam int unsigned NUM_BYTES   = MEM_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [NUM_BYTES-1:0]  wstrb,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [MEM_WIDTH-1:0]  wdata,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [MEM_WIDTH-1:0]  rdata,
  output logic                  rvalid,
  output logic                  busy
);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(MEM_DEPTH - 1);

  logic [MEM_WIDTH-1:0]  r_mem [MEM_DEPTH];
  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_busy;
  logic [MEM_WIDTH-1:0]  r_rdata;
  logic                  r_rvalid;

  logic                  w_waddr_ok;
  logic                  w_raddr_ok;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [MEM_WIDTH-1:0]  w_wr_old;
  logic [MEM_WIDTH-1:0]  w_wr_merged;
  logic [MEM_WIDTH-1:0]  w_rd_old;
  logic [MEM_WIDTH-1:0]  w_rd_word;
  logic [MEM_WIDTH-1:0]  w_out_data;
  logic                  w_out_valid;

  // Addresses past the end are legal on the port when MEM_DEPTH is not a power of two.
  assign w_waddr_ok = 32'(waddr) < MEM_DEPTH;
  assign w_raddr_ok = 32'(raddr) < MEM_DEPTH;
  assign w_wr_acc   = wen & ~r_busy & w_waddr_ok;
  assign w_rd_acc   = ren & ~r_busy;

  // Byte-merge the incoming write into the word currently stored at waddr.
  always_comb begin
    w_wr_old    = w_waddr_ok ? r_mem[waddr] : '0;
    w_wr_merged = w_wr_old;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (wstrb[i]) begin
        w_wr_merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Select the word a read returns, forwarding the merged write in new-data mode.
  always_comb begin
    w_rd_old  = w_raddr_ok ? r_mem[raddr] : '0;
    w_rd_word = w_rd_old;
    if ((RDW_MODE == 1) && w_wr_acc && (waddr == raddr)) begin
      w_rd_word = w_wr_merged;
    end
  end

  // Clear/ready FSM: walk the clear counter over every index, then stay ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StClear;
      r_clr_cnt <= '0;
      r_busy    <= 1'b1;
    end else begin
      unique case (r_state)
        StClear: begin
          if (r_clr_cnt == LastIdx) begin
            r_state <= StReady;
            r_busy  <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
          end
        end
        StReady: begin
          r_state <= StReady;
        end
        default: begin
          r_state <= StClear;
        end
      endcase
    end
  end

  // Storage array: zero-fill while clearing, strobed user writes once ready.
  always_ff @(posedge clk) begin
    if (r_state == StClear) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_acc) begin
      r_mem[waddr] <= w_wr_merged;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                 r_p1_valid;
      logic [MEM_WIDTH-1:0] r_p1_data;

      // Extra stage: data is captured at the accept edge, later writes do not affect it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_p1_valid <= 1'b0;
          r_p1_data  <= '0;
        end else begin
          r_p1_valid <= w_rd_acc;
          if (w_rd_acc) begin
            r_p1_data <= w_rd_word;
          end
        end
      end

      assign w_out_valid = r_p1_valid;
      assign w_out_data  = r_p1_data;
    end else begin : g_lat1
      assign w_out_valid = w_rd_acc;
      assign w_out_data  = w_rd_word;
    end
  endgenerate

  // Output register: rdata only moves when a read completes, rvalid pulses per read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_out_valid;
      if (w_out_valid) begin
        r_rdata <= w_out_data;
      end
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign busy   = r_busy;

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: four instances share stimulus (lat1/old, lat1/new, lat2/old,
// lat1/old with depth 200). Reads push expected data and completion cycle into a
// per-instance queue; a negedge monitor pops and compares on every rvalid.
module tb_data_ram;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen   = 1'b0;
  logic [3:0]  wstrb = '0;
  logic [7:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        ren   = 1'b0;
  logic [7:0]  raddr = '0;
  logic        d_en  = 1'b0;
  logic        wen_d;
  logic        ren_d;

  logic [3:0]  rv;
  logic [3:0]  bz;
  logic [31:0] rd [4];

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  exp_t        q [4][$];
  string       nm [4] = '{"l1_old", "l1_new", "l2_old", "d200"};
  logic [31:0] m_mem [256];
  logic [31:0] d_mem [200];

  assign wen_d = wen & d_en;
  assign ren_d = ren & d_en;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_ram #(.MEM_WIDTH(32), .MEM_DEPTH(256), .READ_LATENCY(1), .RDW_MODE(0)) u_a (
    .clk(clk), .rst(rst), .wen(wen), .wstrb(wstrb), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rd[0]), .rvalid(rv[0]), .busy(bz[0])
  );
  data_ram #(.MEM_WIDTH(32), .MEM_DEPTH(256), .READ_LATENCY(1), .RDW_MODE(1)) u_b (
    .clk(clk), .rst(rst), .wen(wen), .wstrb(wstrb), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rd[1]), .rvalid(rv[1]), .busy(bz[1])
  );
  data_ram #(.MEM_WIDTH(32), .MEM_DEPTH(256), .READ_LATENCY(2), .RDW_MODE(0)) u_c (
    .clk(clk), .rst(rst), .wen(wen), .wstrb(wstrb), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rd[2]), .rvalid(rv[2]), .busy(bz[2])
  );
  data_ram #(.MEM_WIDTH(32), .MEM_DEPTH(200), .READ_LATENCY(1), .RDW_MODE(0)) u_d (
    .clk(clk), .rst(rst), .wen(wen_d), .wstrb(wstrb), .waddr(waddr), .wdata(wdata),
    .ren(ren_d), .raddr(raddr), .rdata(rd[3]), .rvalid(rv[3]), .busy(bz[3])
  );

  // Scoreboard: every rvalid must match the oldest expectation, in data and cycle.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (rv[k]) begin
        total++;
        if (q[k].size() == 0) begin
          bad++;
          $display("FAIL %s_spurious_rvalid: got rvalid=1 rdata=%h cyc=%0d, required no rvalid",
                   nm[k], rd[k], cyc);
        end else begin
          e = q[k].pop_front();
          if (rd[k] !== e.data || cyc != e.cyc) begin
            bad++;
            $display("FAIL %s_read: got rdata=%h cyc=%0d, required rdata=%h cyc=%0d",
                     nm[k], rd[k], cyc, e.data, e.cyc);
          end
        end
      end else if (q[k].size() != 0 && q[k][0].cyc <= cyc) begin
        total++;
        bad++;
        $display("FAIL %s_missing_rvalid: got rvalid=0 cyc=%0d, required rdata=%h",
                 nm[k], cyc, q[k][0].data);
        void'(q[k].pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  task automatic zero_model();
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    for (int i = 0; i < 200; i++) d_mem[i] = '0;
  endtask

  // One cycle of stimulus at the negedge; expectations reflect memory before the write.
  task automatic do_op(input logic we, input logic [3:0] st, input logic [7:0] wa,
                       input logic [31:0] wd, input logic re, input logic [7:0] ra);
    exp_t        e;
    logic [31:0] old;
    @(negedge clk);
    wen = we; wstrb = st; waddr = wa; wdata = wd; ren = re; raddr = ra;
    if (re) begin
      old = m_mem[ra];
      e.data = old; e.cyc = cyc + 1; q[0].push_back(e);
      e.data = (we && wa == ra) ? merge(old, wd, st) : old; q[1].push_back(e);
      e.data = old; e.cyc = cyc + 2; q[2].push_back(e);
      e.data = (ra < 8'd200) ? d_mem[ra] : 32'h0; e.cyc = cyc + 1; q[3].push_back(e);
    end
    if (we) begin
      m_mem[wa] = merge(m_mem[wa], wd, st);
      if (wa < 8'd200) d_mem[wa] = merge(d_mem[wa], wd, st);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    wen = 1'b0; ren = 1'b0; wstrb = '0;
  endtask

  task automatic drain();
    idle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (bz !== 4'hF) begin
      bad++; $display("FAIL reset_busy: got busy=%b, required 1111", bz);
    end
    total++;
    if (rv !== 4'h0) begin
      bad++; $display("FAIL reset_rvalid: got rvalid=%b, required 0000", rv);
    end
    total++;
    if (rd[0] !== 32'h0 || rd[2] !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got %h/%h, required 0", rd[0], rd[2]);
    end
    repeat (3) @(posedge clk);
  endtask

  // Releases reset with requests held high and counts edges until busy drops.
  task automatic test_clear(input string tag);
    int   fall_a;
    int   fall_d;
    logic leak;
    d_en = 1'b0;
    ren = 1'b1; raddr = 8'd5;
    wen = 1'b1; waddr = 8'd5; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    zero_model();
    fall_a = 0; fall_d = 0; leak = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (!bz[3] && fall_d == 0) fall_d = i;
      if (bz[0] && (rv[0] || rd[0] !== 32'h0 || rv[2] || rd[2] !== 32'h0)) leak = 1'b1;
      if (!bz[0]) begin
        fall_a = i;
        break;
      end
    end
    ren = 1'b0; wen = 1'b0; wstrb = '0;
    total++;
    if (fall_a != 256) begin
      bad++; $display("FAIL %s_busy_len256: got %0d cycles, required 256", tag, fall_a);
    end
    total++;
    if (fall_d != 200) begin
      bad++; $display("FAIL %s_busy_len200: got %0d cycles, required 200", tag, fall_d);
    end
    total++;
    if (bz[2:1] !== 2'b00) begin
      bad++; $display("FAIL %s_busy_others: got busy=%b, required 00", tag, bz[2:1]);
    end
    total++;
    if (leak) begin
      bad++; $display("FAIL %s_quiet_while_busy: got rvalid/rdata activity, required none", tag);
    end
    d_en = 1'b1;
  endtask

  task automatic test_read_all_zero();
    for (int i = 0; i < 256; i++) do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'(i));
    drain();
  endtask

  task automatic test_strobes();
    do_op(1'b1, 4'hF, 8'd3, 32'hAABBCCDD, 1'b0, 8'd0);
    do_op(1'b1, 4'b0101, 8'd3, 32'h11223344, 1'b0, 8'd0);
    do_op(1'b1, 4'b0000, 8'd3, 32'h99999999, 1'b0, 8'd0);
    do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd3);
    @(posedge clk); #1;
    total++;
    if (rv[0] !== 1'b1 || rd[0] !== 32'hAA22CC44) begin
      bad++; $display("FAIL strobe_read: got rvalid=%b rdata=%h, required 1 aa22cc44", rv[0], rd[0]);
    end
    idle();
    @(posedge clk); #1;
    total++;
    if (rv[0] !== 1'b0 || rd[0] !== 32'hAA22CC44) begin
      bad++; $display("FAIL strobe_hold: got rvalid=%b rdata=%h, required 0 aa22cc44", rv[0], rd[0]);
    end
    drain();
  endtask

  task automatic test_rdw();
    do_op(1'b1, 4'hF, 8'd7, 32'h12345678, 1'b0, 8'd0);
    do_op(1'b1, 4'b0011, 8'd7, 32'hFFFFFFFF, 1'b1, 8'd7);
    @(posedge clk); #1;
    total++;
    if (rd[0] !== 32'h12345678 || rd[1] !== 32'h1234FFFF) begin
      bad++; $display("FAIL rdw_same_edge: got old=%h new=%h, required 12345678 1234ffff",
                      rd[0], rd[1]);
    end
    do_op(1'b1, 4'hF, 8'd9, 32'hCAFEF00D, 1'b1, 8'd8);
    do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd7);
    do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd9);
    drain();
  endtask

  task automatic test_latency();
    for (int i = 0; i < 4; i++) do_op(1'b1, 4'hF, 8'(i), 32'(10 + i), 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'(i));
    @(posedge clk); #1;
    ren = 1'b0;
    total++;
    if (rv[2] !== 1'b1 || rd[2] !== 32'd12) begin
      bad++; $display("FAIL lat2_third: got rvalid=%b rdata=%h, required 1 0000000c", rv[2], rd[2]);
    end
    @(posedge clk); #1;
    total++;
    if (rv[2] !== 1'b1 || rd[2] !== 32'd13) begin
      bad++; $display("FAIL lat2_fourth: got rvalid=%b rdata=%h, required 1 0000000d", rv[2], rd[2]);
    end
    @(posedge clk); #1;
    total++;
    if (rv[2] !== 1'b0) begin
      bad++; $display("FAIL lat2_end: got rvalid=%b, required 0", rv[2]);
    end
    // Write lands between accept and output of a latency-2 read.
    do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd0);
    do_op(1'b1, 4'hF, 8'd0, 32'd99, 1'b0, 8'd0);
    do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd0);
    drain();
  endtask

  task automatic test_out_of_range();
    do_op(1'b1, 4'hF, 8'd0, 32'hA0A0A0A0, 1'b0, 8'd0);
    do_op(1'b1, 4'hF, 8'd199, 32'hC1C1C1C1, 1'b0, 8'd0);
    do_op(1'b1, 4'hF, 8'd250, 32'hDEADBEEF, 1'b0, 8'd0);
    do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd250);
    @(posedge clk); #1;
    total++;
    if (rv[3] !== 1'b1 || rd[3] !== 32'h0) begin
      bad++; $display("FAIL oor_read250: got rvalid=%b rdata=%h, required 1 00000000", rv[3], rd[3]);
    end
    do_op(1'b1, 4'hF, 8'd250, 32'h55555555, 1'b1, 8'd250);
    do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd199);
    do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] wa;
    logic [7:0] ra;
    for (int n = 0; n < 300; n++) begin
      wa = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(196, 203));
      ra = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(196, 203));
      do_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), wa, $urandom,
            1'($urandom_range(0, 1)), ra);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    do_op(1'b1, 4'hF, 8'd3, 32'h55AA55AA, 1'b0, 8'd0);
    do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd3);
    @(negedge clk);
    ren = 1'b0;
    #2;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) q[k].delete();
    #1;
    total++;
    if (rv !== 4'h0 || rd[0] !== 32'h0 || rd[2] !== 32'h0 || bz !== 4'hF) begin
      bad++; $display("FAIL midread_reset: got rvalid=%b rdata=%h/%h busy=%b, required 0000 0/0 1111",
                      rv, rd[0], rd[2], bz);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    total++;
    if (bz !== 4'hF) begin
      bad++; $display("FAIL midclear_busy: got busy=%b, required 1111", bz);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (rv !== 4'h0 || rd[0] !== 32'h0 || bz !== 4'hF) begin
      bad++; $display("FAIL midclear_reset: got rvalid=%b rdata=%h busy=%b, required 0000 0 1111",
                      rv, rd[0], bz);
    end
    repeat (2) @(posedge clk);
    test_clear("reclear");
    do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd3);
    do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd7);
    do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd199);
    do_op(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd250);
    drain();
  endtask

  initial begin
    test_reset();
    test_clear("clear");
    test_read_all_zero();
    test_strobes();
    test_rdw();
    test_latency();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (q[k].size() != 0) begin
        bad++; $display("FAIL %s_leftover: got %0d pending reads, required 0", nm[k], q[k].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
